// File: rtl/seq_divider_pkg.sv
// seq_divider shared types and helpers.
// State encoding plus conditional two's-complement negate.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] neg(
    input logic [MAX_W-1:0] x
  );
    return ~x + 64'd1;
  endfunction

  // Negate only when the sign flag is set; narrower
  // callers zero-extend and keep the low bits.
  function automatic logic [MAX_W-1:0] abs_val(
    input logic [MAX_W-1:0] x,
    input logic             s
  );
    return s ? neg(x) : x;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// seq_divider restoring iteration.
// One shift-subtract step of radix-2 restoring division.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift {rem,q}, trial-subtract, keep if non-negative.
  always_comb begin
    shifted  = {rem, q[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    rem_next = shifted[WIDTH-1:0];
    q_next   = {q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider top: FSM, operand capture, sign fix.
// Multi-cycle signed/unsigned restoring divider.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MIN_V =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvs_r;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             b_zero;
  logic             s_ovf;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign a_neg  = op_signed & a[WIDTH-1];
  assign b_neg  = op_signed & b[WIDTH-1];
  assign a_mag  = WIDTH'(abs_val(64'(a), a_neg));
  assign b_mag  = WIDTH'(abs_val(64'(b), b_neg));
  assign b_zero = (b == '0);
  assign s_ovf  = op_signed && (a == MIN_V) && (b == '1);
  assign q_fix  = WIDTH'(abs_val(64'(q_nx), q_neg));
  assign r_fix  = WIDTH'(abs_val(64'(rem_nx), r_neg));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .divisor  (dvs_r),
    .rem_next (rem_nx),
    .q_next   (q_nx)
  );

  // Control FSM with registered results and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      rem_r         <= '0;
      q_r           <= '0;
      dvs_r         <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      busy          <= 1'b0;
      ready         <= 1'b0;
      quotient      <= '0;
      remainder_out <= '0;
      div_by_zero   <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            q_neg       <= a_neg ^ b_neg;
            r_neg       <= a_neg;
            if (b_zero) begin
              state         <= DONE;
              ready         <= 1'b1;
              quotient      <= '1;
              remainder_out <= a;
              div_by_zero   <= 1'b1;
            end else if (s_ovf) begin
              state         <= DONE;
              ready         <= 1'b1;
              quotient      <= a;
              remainder_out <= '0;
              overflow      <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              cnt   <= CNT_W'(WIDTH);
              rem_r <= '0;
              q_r   <= a_mag;
              dvs_r <= b_mag;
            end
          end
        end
        CALC: begin
          rem_r <= rem_nx;
          q_r   <= q_nx;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state         <= DONE;
            busy          <= 1'b0;
            ready         <= 1'b1;
            quotient      <= q_fix;
            remainder_out <= r_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// seq_divider bench: directed cases plus random sweep
// against a plain-arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start64, sgn64, start32, sgn32;
  logic [63:0] a64, b64;
  logic [31:0] a32, b32;
  logic        busy64, ready64, dz64, ov64;
  logic        busy32, ready32, dz32, ov32;
  logic [63:0] q64, r64;
  logic [31:0] q32, r32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(64)) dut64 (
    .clk (clk), .rst (rst), .start (start64),
    .op_signed (sgn64), .a (a64), .b (b64),
    .busy (busy64), .ready (ready64),
    .quotient (q64), .remainder_out (r64),
    .div_by_zero (dz64), .overflow (ov64)
  );

  seq_divider #(.WIDTH(32)) dut32 (
    .clk (clk), .rst (rst), .start (start32),
    .op_signed (sgn32), .a (a32), .b (b32),
    .busy (busy32), .ready (ready32),
    .quotient (q32), .remainder_out (r32),
    .div_by_zero (dz32), .overflow (ov32)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: SV integer / and % truncate toward zero
  // with the remainder taking the dividend's sign.
  task automatic ref_div(
    input  int          w,
    input  bit          sgn,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] q,
    output logic [63:0] r,
    output bit          dz,
    output bit          ov
  );
    logic [63:0] mask;
    longint      sa, sb;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a &= mask;
    b &= mask;
    dz = 0;
    ov = 0;
    if (b == 0) begin
      q  = mask;
      r  = a;
      dz = 1;
    end else if (sgn && a == (64'd1 << (w - 1))
                 && b == mask) begin
      q  = a;
      r  = 0;
      ov = 1;
    end else if (sgn) begin
      sa = longint'(a << (64 - w)) >>> (64 - w);
      sb = longint'(b << (64 - w)) >>> (64 - w);
      q  = 64'(sa / sb) & mask;
      r  = 64'(sa % sb) & mask;
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic drive(
    input int          w,
    input logic        st,
    input logic        sgn,
    input logic [63:0] a,
    input logic [63:0] b
  );
    if (w == 64) begin
      start64 = st; sgn64 = sgn; a64 = a; b64 = b;
    end else begin
      start32 = st; sgn32 = sgn;
      a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  function automatic logic o_rdy(input int w);
    return (w == 64) ? ready64 : ready32;
  endfunction
  function automatic logic o_busy(input int w);
    return (w == 64) ? busy64 : busy32;
  endfunction
  function automatic logic [63:0] o_q(input int w);
    return (w == 64) ? q64 : {32'd0, q32};
  endfunction
  function automatic logic [63:0] o_r(input int w);
    return (w == 64) ? r64 : {32'd0, r32};
  endfunction
  function automatic logic [1:0] o_fl(input int w);
    return (w == 64) ? {dz64, ov64} : {dz32, ov32};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; inj>0 pulses a stray start with junk
  // operands that many edges into the calculation.
  task automatic run_op(
    input int          w,
    input bit          sgn,
    input logic [63:0] a,
    input logic [63:0] b,
    input int          inj,
    input string       tag
  );
    logic [63:0] eq, er;
    bit          edz, eov;
    int          n, lat;
    ref_div(w, sgn, a, b, eq, er, edz, eov);
    lat = (edz || eov) ? 0 : w;
    @(negedge clk);
    drive(w, 1'b1, sgn, a, b);
    tick();
    drive(w, 1'b0, $urandom_range(0, 1),
          {$urandom, $urandom}, {$urandom, $urandom});
    n = 0;
    while (!o_rdy(w) && n < 200) begin
      if (n == inj && inj > 0)
        drive(w, 1'b1, ~sgn, 64'd999, 64'd3);
      tick();
      drive(w, 1'b0, sgn, 64'd0, 64'd0);
      n++;
    end
    check({tag, ".lat"}, 64'(n), 64'(lat));
    check({tag, ".q"}, o_q(w), eq);
    check({tag, ".r"}, o_r(w), er);
    check({tag, ".flags"}, 64'(o_fl(w)), 64'({edz, eov}));
    check({tag, ".busy"}, 64'(o_busy(w)), 64'd0);
  endtask

  logic [63:0] ra, rb, sq, sr;
  int          kind, w;

  initial begin
    rst = 1'b1;
    drive(64, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    tick();
    tick();
    check("rst.busy", 64'(busy64), 64'd0);
    check("rst.ready", 64'(ready64), 64'd0);
    check("rst.q", q64, 64'd0);
    check("rst.r", r64, 64'd0);
    check("rst.flags32", 64'({dz32, ov32, busy32}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(64, 0, 64'd100, 64'd7, 0, "t1");
    run_op(64, 1, -64'sd7, 64'sd2, 0, "t2a");
    run_op(64, 1, 64'sd7, -64'sd2, 0, "t2b");
    check("t2b.qv", q64, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(64, 0, 64'd5, 64'd0, 0, "t3u");
    run_op(64, 1, 64'd5, 64'd0, 0, "t3s");
    run_op(64, 0, 64'd9, 64'd4, 0, "t3clr");
    run_op(64, 1, 64'h8000_0000_0000_0000, '1, 0, "t4s");
    run_op(64, 0, 64'h8000_0000_0000_0000, '1, 0, "t4u");
    run_op(64, 1, 64'h8000_0000_0000_0000, 64'd2, 0,
           "tmin2");
    run_op(64, 1, -64'sd6, 64'sd3, 0, "tzero_r");

    // Results hold in DONE while inputs wiggle.
    sq = q64;
    sr = r64;
    repeat (3) begin
      @(negedge clk);
      drive(64, 1'b0, 1'b1, {$urandom, $urandom}, 64'd1);
    end
    tick();
    check("hold.q", q64, sq);
    check("hold.r", r64, sr);
    check("hold.rdy", 64'(ready64), 64'd1);

    run_op(64, 0, 64'd100, 64'd7, 10, "t5ign");

    // Reset abandons an operation in progress.
    @(negedge clk);
    drive(64, 1'b1, 1'b0, 64'd12345, 64'd17);
    tick();
    drive(64, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (19) tick();
    check("t5mid.busy", 64'(busy64), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("t5rst.busy", 64'(busy64), 64'd0);
    check("t5rst.ready", 64'(ready64), 64'd0);
    check("t5rst.q", q64, 64'd0);
    check("t5rst.r", r64, 64'd0);
    check("t5rst.fl", 64'({dz64, ov64}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(64, 0, 64'd12345, 64'd17, 0, "t5new");

    run_op(32, 0, 64'hFFFF_FFFF, 64'd1, 0, "t6");
    run_op(32, 1, 64'h8000_0000, 64'hFFFF_FFFF, 0,
           "t6ov");
    run_op(32, 1, 64'hFFFF_FFF9, 64'd2, 0, "t6neg");

    for (int i = 0; i < 60; i++) begin
      w    = (i % 2 == 0) ? 64 : 32;
      kind = $urandom_range(0, 9);
      ra   = {$urandom, $urandom} >> $urandom_range(0, 60);
      rb   = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      if ($urandom_range(0, 1) == 1) rb = -rb;
      if (kind == 0) rb = 64'd0;
      if (kind == 1) begin
        ra = 64'd1 << (w - 1);
        rb = '1;
      end
      if (kind == 2) rb = 64'($urandom_range(1, 9));
      run_op(w, 1'($urandom_range(0, 1)), ra, rb, 0,
             $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
